// File: rtl/check_scan_pkg.sv
// Shared types and constants for the debug check-bus scan reader.
package check_scan_pkg;

  // Default geometry of the debug check bus.
  localparam int CS_ADDR_W      = 5;
  localparam int CS_DATA_W      = 32;
  localparam int CS_NUM_ENTRIES = 25;

  // Entry indices of named debug signals on the check bus.
  localparam int IDX_STALL_IF   = 18;
  localparam int IDX_FLUSH_MEM  = 24;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    FIN     = 3'd4
  } state_e;

endpackage

// File: rtl/check_scan_reader.sv
// check_scan_reader: sweeps the debug check bus over entries 0..NUM_ENTRIES-1,
// waits SETTLE_CYC cycles per address for the mux to settle, captures the
// returned word and presents it on a valid/ready stream for the dump path.
// Optional build macro CHECK_SCAN_CONTINUOUS_EN: sweeps repeat back to back
// until an abort pulse on stop_req; without it each start gives one sweep.
module check_scan_reader
  import check_scan_pkg::*;
#(
  parameter int ADDR_W      = CS_ADDR_W,
  parameter int DATA_W      = CS_DATA_W,
  parameter int NUM_ENTRIES = CS_NUM_ENTRIES,
  parameter int SETTLE_CYC  = 1          // legal range 1..15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic [ADDR_W-1:0] check_addr,
  input  logic [DATA_W-1:0] check_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef CHECK_SCAN_CONTINUOUS_EN
  ,
  input  logic              stop_req
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   oaddr_q, oaddr_d;
  logic [DATA_W-1:0]   odata_q, odata_d;
  logic                busy_q, busy_d;
  logic                stop_q, stop_d;
  logic                stop_in;

`ifdef CHECK_SCAN_CONTINUOUS_EN
  assign stop_in = stop_req;
`else
  assign stop_in = 1'b0;
`endif

  // State and datapath registers; reset returns every output to idle values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state logic: settle, capture, hand off, then step or finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    busy_d  = busy_q;
    // An abort request is remembered until the current entry is handed off.
    stop_d  = stop_q || (stop_in && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          busy_d  = 1'b1;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        odata_d = check_data;
        oaddr_d = addr_q;
        valid_d = 1'b1;
        state_d = EMIT;
      end

      EMIT: begin
        // Address and captured word stay frozen until the consumer accepts.
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (stop_q || stop_in) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            addr_d  = '0;
            stop_d  = 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end

      FIN: begin
        addr_d = '0;
`ifdef CHECK_SCAN_CONTINUOUS_EN
        cnt_d   = '0;
        state_d = SETTLE;
`else
        busy_d  = 1'b0;
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign check_addr = addr_q;
  assign out_valid  = valid_q;
  assign out_addr   = oaddr_q;
  assign out_data   = odata_q;
  assign busy       = busy_q;
  // done is high exactly for the single cycle spent in FIN.
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_check_scan_reader.sv
// Bench for check_scan_reader: one instance with SETTLE_CYC=1 driven through a
// table of per-entry records, and one with SETTLE_CYC=4 fed by a slow mux model.
module tb_check_scan_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NE = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          start, out_ready, perturb;
  logic [AW-1:0] check_addr, out_addr;
  logic [DW-1:0] check_data, out_data;
  logic          out_valid, busy, done;

  logic          b_start, b_ready;
  logic [AW-1:0] b_addr, b_out_addr;
  logic [DW-1:0] b_data, b_out_data;
  logic          b_valid, b_busy, b_done;

  logic          stop_a, stop_b;

  // Fast mux: word is A000_0000+addr, scrambled while perturb is set.
  assign check_data = (32'hA000_0000 + {27'd0, check_addr}) ^ (perturb ? 32'h0F0F_0000 : 32'h0);

  // Slow mux: shows garbage until the address has been stable for a while.
  logic [AW-1:0] b_seen = '0;
  int            b_age  = 3;
  always @(posedge clk) begin
    if (b_addr != b_seen) begin
      b_seen <= b_addr;
      b_age  <= 0;
    end else if (b_age < 3) begin
      b_age <= b_age + 1;
    end
  end
  assign b_data = (b_addr == b_seen && b_age >= 3) ? (32'hA000_0000 + {27'd0, b_addr}) : 32'hDEAD_BEEF;

  check_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(NE), .SETTLE_CYC(1)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .check_addr(check_addr), .check_data(check_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done)
`ifdef CHECK_SCAN_CONTINUOUS_EN
    , .stop_req(stop_a)
`endif
  );

  check_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_ENTRIES(NE), .SETTLE_CYC(4)) dut_b (
    .clk(clk), .rstn(rstn), .start(b_start), .check_addr(b_addr), .check_data(b_data),
    .out_valid(b_valid), .out_ready(b_ready), .out_addr(b_out_addr), .out_data(b_out_data),
    .busy(b_busy), .done(b_done)
`ifdef CHECK_SCAN_CONTINUOUS_EN
    , .stop_req(stop_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    int          rdy_low;   // cycles out_ready is held low once the entry shows
    bit          kick;      // pulse start while this entry is presented
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[NE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume entries first..last of the table on instance A.
  task automatic run_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int n;
      bit stable;
      out_ready = (tbl[i].rdy_low == 0);
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) begin
        check($sformatf("valid_wait[%0d]", i), 32'(out_valid), 1);
        return;
      end
      check($sformatf("out_addr[%0d]", i), 32'(out_addr), 32'(tbl[i].exp_addr));
      check($sformatf("out_data[%0d]", i), out_data, tbl[i].exp_data);
      check($sformatf("check_addr[%0d]", i), 32'(check_addr), 32'(tbl[i].exp_addr));
      if (tbl[i].rdy_low > 0) begin
        perturb = 1'b1;
        stable  = 1'b1;
        repeat (tbl[i].rdy_low) begin
          @(negedge clk);
          if (!out_valid || out_addr !== tbl[i].exp_addr || out_data !== tbl[i].exp_data ||
              check_addr !== tbl[i].exp_addr) stable = 1'b0;
        end
        check($sformatf("stall_stable[%0d]", i), 32'(stable), 1);
        perturb   = 1'b0;
        out_ready = 1'b1;
      end
      if (tbl[i].kick) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("valid_drop[%0d]", i), 32'(out_valid), 0);
    end
  endtask

  // Called at the sample right after the last entry was accepted.
  task automatic finish_sweep(input int c0, input int exp_cyc);
    check("done_pulse", 32'(done), 1);
    check("sweep_cycles", cyc - c0, exp_cyc);
`ifdef CHECK_SCAN_CONTINUOUS_EN
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("busy_held", 32'(busy), 1);
    check("addr_wrap", 32'(check_addr), 0);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    check("stop_idle", 32'(busy), 0);
`else
    start = 1'b1;               // start coinciding with done must be ignored
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("busy_clear", 32'(busy), 0);
    check("addr_clear", 32'(check_addr), 0);
    @(negedge clk);
    check("start_on_done_ignored", 32'(busy), 0);
`endif
  endtask

  initial begin
    int c0;
    int saved;

    for (int i = 0; i < NE; i++) begin
      tbl[i].rdy_low  = 0;
      tbl[i].kick     = 1'b0;
      tbl[i].exp_addr = 5'(i);
      tbl[i].exp_data = 32'hA000_0000 + 32'(i);
    end
    tbl[0].exp_data  = 32'hA000_0000;
    tbl[5].exp_data  = 32'hA000_0005;
    tbl[12].exp_data = 32'hA000_000C;
    tbl[18].exp_data = 32'hA000_0012;
    tbl[24].exp_data = 32'hA000_0018;

    rstn = 1'b0; start = 1'b0; out_ready = 1'b0; perturb = 1'b0;
    b_start = 1'b0; b_ready = 1'b1; stop_a = 1'b0; stop_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_check_addr", 32'(check_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_addr", 32'(out_addr), 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_no_valid", 32'(out_valid), 0);

    // Plain sweep, consumer always ready: 3 cycles per entry.
    pulse_start();
    c0 = cyc;
    check("busy_after_start", 32'(busy), 1);
    run_table(0, NE - 1);
    finish_sweep(c0, 75);
    check("done_count_1", done_cnt, 1);

    // Backpressure at entry 5 while the mux output changes underneath.
    tbl[5].rdy_low = 10;
    pulse_start();
    c0 = cyc;
    run_table(0, NE - 1);
    finish_sweep(c0, 85);
    tbl[5].rdy_low = 0;
    check("done_count_2", done_cnt, 2);

    // Reset mid-sweep at entry 7: outputs clear without a clock edge.
    saved = done_cnt;
    pulse_start();
    run_table(0, 6);
    out_ready = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check("pre_rst_entry", 32'(out_addr), 7);
    #2 rstn = 1'b0;
    #1;
    check("arst_check_addr", 32'(check_addr), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("arst_no_done", done_cnt, saved);
    check("arst_stays_idle", 32'(busy), 0);

    // Restart after reset, with a stray start at entry 12.
    tbl[12].kick = 1'b1;
    pulse_start();
    c0 = cyc;
    run_table(0, NE - 1);
    finish_sweep(c0, 75);
    tbl[12].kick = 1'b0;
    check("single_done", done_cnt, saved + 1);

    // Slow mux on instance B, SETTLE_CYC=4.
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < NE; i++) begin
      for (int n = 0; n < 60 && !b_valid; n++) @(negedge clk);
      check($sformatf("b_addr[%0d]", i), 32'(b_out_addr), 32'(i));
      check($sformatf("b_data[%0d]", i), b_out_data, 32'hA000_0000 + 32'(i));
      @(negedge clk);
    end
    check("b_done", 32'(b_done), 1);
`ifdef CHECK_SCAN_CONTINUOUS_EN
    stop_b = 1'b1;
    @(negedge clk);
    stop_b = 1'b0;
    for (int n = 0; n < 40 && b_busy; n++) @(negedge clk);
    check("b_stop_idle", 32'(b_busy), 0);

    // Repeating sweeps, aborted at entry 3 of the second sweep.
    saved = done_cnt;
    pulse_start();
    run_table(0, NE - 1);
    check("cont_done", 32'(done), 1);
    @(negedge clk);
    check("cont_busy_held", 32'(busy), 1);
    check("cont_addr_wrap", 32'(check_addr), 0);
    run_table(0, 2);
    out_ready = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    check("cont_entry3", 32'(out_addr), 3);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("cont_still_busy", 32'(busy), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("cont_stop_busy", 32'(busy), 0);
    check("cont_stop_valid", 32'(out_valid), 0);
    repeat (5) @(negedge clk);
    check("cont_stop_no_done", done_cnt, saved + 1);
    check("cont_stays_idle", 32'(out_valid), 0);
`else
    @(negedge clk);
    check("b_busy_clear", 32'(b_busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
